// File: rtl/nbcac_pkg.sv
// Shared NBCAC numeral-system constants for the 14-wire link.
// The encoder and decoder cores both import this package, so they use the same weight table.
package nbcac_pkg;

   localparam int NBCAC_N = 14;
   localparam int NBCAC_K = 10;

   // Codeword bit k carries weight NBCAC_W[k]. The table is the Fibonacci run 1, 2, 3, 5, ..., 610.
   // Every weight is at most one more than the sum of the weights below it, so every
   // 10-bit value 0..1023 has a codeword. An all-ones codeword sums to 1595.
   localparam logic [11:0] NBCAC_W [14:1] = '{
      12'd610, 12'd377, 12'd233, 12'd144, 12'd89, 12'd55, 12'd34,
      12'd21,  12'd13,  12'd8,   12'd5,   12'd3,  12'd2,  12'd1
   };

   localparam logic [11:0] NBCAC_MAX = 12'd1023;

endpackage

// File: rtl/nbcac_decoder_14_core.sv
// Combinational NBCAC decoder core: weighted sum of the codeword bits.
// This core is the inverse of nbcac_10di_encoder_core.
import nbcac_pkg::*;

module nbcac_10di_decoder_core (
   input  logic [NBCAC_N:1]   d,
   output logic [NBCAC_K-1:0] v,
   output logic               oor
);

   logic [11:0] sum;

   // Accumulate the weight of every set codeword bit on a 12-bit unsigned accumulator
   always_comb begin
      sum = '0;
      for (int k = 1; k <= NBCAC_N; k++) begin
         if (d[k]) sum = sum + NBCAC_W[k];
      end
   end

   assign v   = sum[NBCAC_K-1:0];
   assign oor = (sum > NBCAC_MAX);

endmodule

// File: rtl/nbcac_decoder_14.sv
// Pipelined receive-side NBCAC decoder. It has two stalling register stages
// (capture, then result), a valid/ready handshake, and a saturating error counter.
import nbcac_pkg::*;

module nbcac_decoder_14 #(
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic [NBCAC_N:1]     codein,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [NBCAC_K-1:0]   dataout,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count,
   input  logic                 err_clr
);

   // Both stages advance together. There is no bubble collapsing.
   logic adv;
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   logic [NBCAC_N:1]   code_p1;
   logic               vld_p1;
   logic [NBCAC_K-1:0] dec_v;
   logic               dec_oor;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      return (&c) ? c : c + ERR_CNT_W'(1);
   endfunction

   // Stage 1: capture the bus codeword. Data loads only with a valid word.
   always_ff @(posedge clock) begin
      if (rst) begin
         code_p1 <= '0;
         vld_p1  <= 1'b0;
      end else if (adv) begin
         vld_p1 <= in_valid;
         if (in_valid) code_p1 <= codein;
      end
   end

   nbcac_10di_decoder_core u_core (
      .d   (code_p1),
      .v   (dec_v),
      .oor (dec_oor)
   );

   // Stage 2: register the decoded word and its range flag
   always_ff @(posedge clock) begin
      if (rst) begin
         dataout   <= '0;
         out_err   <= 1'b0;
         out_valid <= 1'b0;
      end else if (adv) begin
         out_valid <= vld_p1;
         if (vld_p1) begin
            dataout <= dec_v;
            out_err <= dec_oor;
         end
      end
   end

   // Count delivered erroneous words. A clear takes priority over an increment.
   always_ff @(posedge clock) begin
      if (rst || err_clr) begin
         err_count <= '0;
      end else if (out_valid && out_ready && out_err) begin
         err_count <= sat_inc(err_count);
      end
   end

endmodule

// File: tb/tb_nbcac_decoder_14.sv
// Scoreboard bench for nbcac_decoder_14: directed and random stimulus against a
// weighted-sum reference model. A second instance with a 2-bit counter exercises saturation.
module tb_nbcac_decoder_14;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst, in_valid, out_ready, err_clr;
   logic [14:1] codein;
   logic        in_ready, out_valid, out_err;
   logic [9:0]  dataout;
   logic [15:0] err_count;
   logic        in_ready2, out_valid2, out_err2;
   logic [9:0]  dataout2;
   logic [1:0]  err_count2;

   nbcac_decoder_14 #(.ERR_CNT_W(16)) u_dut (
      .clock(clock), .rst(rst), .codein(codein), .in_valid(in_valid), .in_ready(in_ready),
      .dataout(dataout), .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
      .err_count(err_count), .err_clr(err_clr)
   );

   nbcac_decoder_14 #(.ERR_CNT_W(2)) u_dut2 (
      .clock(clock), .rst(rst), .codein(codein), .in_valid(in_valid), .in_ready(in_ready2),
      .dataout(dataout2), .out_valid(out_valid2), .out_ready(out_ready), .out_err(out_err2),
      .err_count(err_count2), .err_clr(err_clr)
   );

   // Reference weights, index 1..14
   int wt [1:14] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};

   typedef struct {
      logic [9:0] d;
      logic       e;
      int         cyc;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   lat_chk = 1'b0;
   bit   mon_on = 1'b0;
   int   mcnt = 0;
   int   mcnt2 = 0;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic int wsum(input logic [14:1] c);
      int s = 0;
      for (int k = 1; k <= 14; k++) if (c[k]) s += wt[k];
      return s;
   endfunction

   // Greedy numeral-system encoding: take the largest weight that still fits
   function automatic logic [14:1] encode(input int val);
      logic [14:1] c = '0;
      int r = val;
      for (int k = 14; k >= 1; k--) begin
         if (r >= wt[k]) begin
            c[k] = 1'b1;
            r -= wt[k];
         end
      end
      return c;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [9:0] d, input logic e);
      exp_t x;
      x.d = d;
      x.e = e;
      x.cyc = cyc;
      sbq.push_back(x);
   endtask

   // Present a word and hold it until accepted. Called and returns at posedge+1.
   task automatic send_x(input logic [14:1] c, input logic [9:0] d, input logic e);
      int n = 0;
      codein = c;
      in_valid = 1'b1;
      @(negedge clock);
      while (!in_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      else push(d, e);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [14:1] c);
      int s = wsum(c);
      send_x(c, s[9:0], s > 1023);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Monitor: check the counter every cycle and pop the scoreboard on each output handshake
   initial begin
      bit hs_err;
      exp_t x;
      forever begin
         @(negedge clock);
         hs_err = 1'b0;
         if (mon_on && !rst) begin
            chk("err_count", err_count, mcnt);
            chk("err_count_w2", err_count2, mcnt2);
            if (out_valid && out_ready) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_output", 1, 0);
               end else begin
                  x = sbq.pop_front();
                  hs_err = x.e;
                  chk("dataout", dataout, x.d);
                  chk("out_err", out_err, x.e);
                  chk("dataout_w2", dataout2, x.d);
                  chk("out_valid_w2", out_valid2, 1);
                  if (lat_chk) chk("latency", cyc - x.cyc, 2);
               end
            end
         end
         if (rst || err_clr) begin
            mcnt = 0;
            mcnt2 = 0;
         end else if (hs_err) begin
            if (mcnt < 65535) mcnt++;
            if (mcnt2 < 3) mcnt2++;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [14:1] ca, cb, cc;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      err_clr = 1'b0;
      codein = '0;
      repeat (2) @(posedge clock);
      #1;
      rst = 1'b0;
      mon_on = 1'b1;
      @(negedge clock);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dataout", dataout, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clock);
      #1;

      // Round trip of every data value with a continuously ready consumer
      lat_chk = 1'b1;
      for (int v = 0; v < 1024; v++) send_x(encode(v), v[9:0], 1'b0);
      idle(4);
      lat_chk = 1'b0;
      chk("roundtrip_drain", sbq.size(), 0);
      chk("roundtrip_err_count", err_count, 0);

      // Zero word
      send_x(14'h0000, 10'd0, 1'b0);
      idle(4);

      // Out-of-range words. An all-ones codeword sums to 1595, so the low bits are 571.
      for (int i = 0; i < 4; i++) send_x(14'h3FFF, 10'd571, 1'b1);
      idle(4);
      chk("oor_count4", err_count, 4);
      chk("oor_count_sat", err_count2, 3);

      // A clear in the same cycle as an error handshake wins
      send_x(14'h3FFF, 10'd571, 1'b1);
      @(posedge clock);
      #1;
      err_clr = 1'b1;
      @(posedge clock);
      #1;
      err_clr = 1'b0;
      @(negedge clock);
      chk("clr_priority", err_count, 0);
      chk("clr_priority_w2", err_count2, 0);
      idle(2);

      // Backpressure: stall A on the output for 5 cycles with C waiting
      ca = encode(100);
      cb = encode(200);
      cc = encode(300);
      send(ca);
      send(cb);
      out_ready = 1'b0;
      codein = cc;
      in_valid = 1'b1;
      repeat (5) begin
         @(negedge clock);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_in_ready_w2", in_ready2, 0);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_dataout", dataout, 100);
         @(posedge clock);
         #1;
      end
      out_ready = 1'b1;
      send(cc);
      idle(4);
      chk("bp_drain", sbq.size(), 0);

      // Random traffic with bubbles, backpressure and occasional clears
      for (int i = 0; i < 400; i++) begin
         int s;
         in_valid = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         err_clr = ($urandom % 32) == 0;
         codein = ($urandom % 2) ? encode($urandom % 1024) : 14'($urandom);
         s = wsum(codein);
         @(negedge clock);
         if (in_valid && in_ready) push(s[9:0], s > 1023);
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      err_clr = 1'b0;
      idle(4);
      chk("rand_drain", sbq.size(), 0);

      // Reset with two words in flight: neither may appear afterwards
      send_x(14'h3FFF, 10'd571, 1'b1);
      idle(3);
      send_x(14'h3FFF, 10'd571, 1'b1);
      out_ready = 1'b0;
      send(encode(777));
      rst = 1'b1;
      sbq.delete();
      @(posedge clock);
      #1;
      rst = 1'b0;
      @(negedge clock);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_dataout", dataout, 0);
      chk("midrst_out_err", out_err, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      idle(6);
      chk("midrst_no_output", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
